// File: rtl/torreta_arbitro_servo_pkg.sv
// Shared definitions for the reload/fire servo arbiter of the torreta:
// state codes (also shown on the debug display) and servo position codes.
package torreta_arbitro_servo_pkg;

    typedef enum logic [3:0] {
        OCIOSO      = 4'h0,
        DISPARO     = 4'h1,
        RET_DISPARO = 4'h2,
        RECARGA     = 4'h3,
        RET_RECARGA = 4'h4,
        REJEITA     = 4'hF
    } estado_t;

    localparam logic [1:0] POS_REPOUSO = 2'b00;
    localparam logic [1:0] POS_DISPARO = 2'b01;
    localparam logic [1:0] POS_RECARGA = 2'b10;

    localparam int MAX_MUNICAO_PADRAO = 9;

    // States in which the servo timer runs
    function automatic logic estado_temporizado(input estado_t e);
        case (e)
            DISPARO, RET_DISPARO, RECARGA, RET_RECARGA: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    // Action states hold the servo away from rest for T_ACAO cycles
    function automatic logic estado_acao(input estado_t e);
        case (e)
            DISPARO, RECARGA: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/torreta_arbitro_servo_temporizador.sv
// Free-running dwell timer: counts while enabled, clears on request and
// flags the cycle in which the count reaches the programmed limit.
module torreta_temporizador #(
    parameter int W_TEMPO = 25
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               limpa,
    input  logic               habilita,
    input  logic [W_TEMPO-1:0] limite,
    output logic               fim
);

    logic [W_TEMPO-1:0] contagem_r;

    // Dwell counter; clear wins over enable so every state entry starts at zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem_r <= {W_TEMPO{1'b0}};
        end else if (limpa) begin
            contagem_r <= {W_TEMPO{1'b0}};
        end else if (habilita) begin
            contagem_r <= contagem_r + {{(W_TEMPO-1){1'b0}}, 1'b1};
        end else begin
            contagem_r <= contagem_r;
        end
    end

    assign fim = habilita && (contagem_r == limite);

endmodule

// File: rtl/torreta_arbitro_servo.sv
// Arbitrates fire and reload requests onto the shared servo, owns the
// ammunition count and reports completion/rejection back to the UC.
module torreta_arbitro_servo
    import torreta_arbitro_servo_pkg::*;
#(
    parameter int MAX_MUNICAO = MAX_MUNICAO_PADRAO,
    parameter int T_ACAO      = 25_000_000,
    parameter int T_RETORNO   = 25_000_000,
    parameter int W_TEMPO     = 25
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pedido_disparo,
    input  logic       pedido_recarga,
    output logic [1:0] posicao_servo,
    output logic       fim_disparo,
    output logic       fim_recarga,
    output logic       falha,
    output logic       ocupado,
    output logic [3:0] contagem_municao,
    output logic       torreta_carregada,
    output logic [3:0] db_estado
);

    // The timer counts 0..limit, so a dwell of T cycles compares against T-1
    localparam logic [W_TEMPO-1:0] LIM_ACAO    = W_TEMPO'(T_ACAO - 1);
    localparam logic [W_TEMPO-1:0] LIM_RETORNO = W_TEMPO'(T_RETORNO - 1);
    localparam logic [3:0]         MAX_CONT    = 4'(MAX_MUNICAO);

    estado_t            estado_r;
    logic [1:0]         posicao_r;
    logic               fim_disparo_r;
    logic               fim_recarga_r;
    logic               falha_r;
    logic               pendente_r;
    logic [3:0]         contagem_r;

    logic               temporizado_s;
    logic               limpa_s;
    logic               fim_tempo_s;
    logic [W_TEMPO-1:0] limite_s;

    // Timer control: idle states hold it cleared, expiry clears it for the next state
    always_comb begin
        temporizado_s = estado_temporizado(estado_r);
        limpa_s       = !temporizado_s || fim_tempo_s;
        if (estado_acao(estado_r)) begin
            limite_s = LIM_ACAO;
        end else begin
            limite_s = LIM_RETORNO;
        end
    end

    torreta_temporizador #(
        .W_TEMPO (W_TEMPO)
    ) u_temporizador (
        .clock    (clock),
        .reset    (reset),
        .limpa    (limpa_s),
        .habilita (temporizado_s),
        .limite   (limite_s),
        .fim      (fim_tempo_s)
    );

    // Sequencing FSM with ammo counter, pending-reload flag and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_r      <= OCIOSO;
            posicao_r     <= POS_REPOUSO;
            fim_disparo_r <= 1'b0;
            fim_recarga_r <= 1'b0;
            falha_r       <= 1'b0;
            pendente_r    <= 1'b0;
            contagem_r    <= 4'd0;
        end else begin
            fim_disparo_r <= 1'b0;
            fim_recarga_r <= 1'b0;
            falha_r       <= 1'b0;

            // Reloads arriving while busy collapse into one pending request
            if ((estado_r != OCIOSO) && pedido_recarga) begin
                pendente_r <= 1'b1;
            end else begin
                pendente_r <= pendente_r;
            end

            case (estado_r)
                OCIOSO: begin
                    if (pedido_disparo) begin
                        if (pedido_recarga) begin
                            pendente_r <= 1'b1;
                        end else begin
                            pendente_r <= pendente_r;
                        end
                        if (contagem_r != 4'd0) begin
                            estado_r   <= DISPARO;
                            posicao_r  <= POS_DISPARO;
                            contagem_r <= contagem_r - 4'd1;
                        end else begin
                            estado_r   <= REJEITA;
                            falha_r    <= 1'b1;
                        end
                    end else if (pedido_recarga || pendente_r) begin
                        pendente_r <= 1'b0;
                        if (contagem_r < MAX_CONT) begin
                            estado_r   <= RECARGA;
                            posicao_r  <= POS_RECARGA;
                            contagem_r <= contagem_r + 4'd1;
                        end else begin
                            estado_r   <= REJEITA;
                            falha_r    <= 1'b1;
                        end
                    end else begin
                        estado_r <= OCIOSO;
                    end
                end
                DISPARO: begin
                    if (fim_tempo_s) begin
                        estado_r  <= RET_DISPARO;
                        posicao_r <= POS_REPOUSO;
                    end else begin
                        estado_r  <= DISPARO;
                    end
                end
                RET_DISPARO: begin
                    if (fim_tempo_s) begin
                        estado_r      <= OCIOSO;
                        fim_disparo_r <= 1'b1;
                    end else begin
                        estado_r      <= RET_DISPARO;
                    end
                end
                RECARGA: begin
                    if (fim_tempo_s) begin
                        estado_r  <= RET_RECARGA;
                        posicao_r <= POS_REPOUSO;
                    end else begin
                        estado_r  <= RECARGA;
                    end
                end
                RET_RECARGA: begin
                    if (fim_tempo_s) begin
                        estado_r      <= OCIOSO;
                        fim_recarga_r <= 1'b1;
                    end else begin
                        estado_r      <= RET_RECARGA;
                    end
                end
                REJEITA: begin
                    estado_r  <= OCIOSO;
                    posicao_r <= POS_REPOUSO;
                end
                default: begin
                    estado_r  <= OCIOSO;
                    posicao_r <= POS_REPOUSO;
                end
            endcase
        end
    end

    assign posicao_servo     = posicao_r;
    assign fim_disparo       = fim_disparo_r;
    assign fim_recarga       = fim_recarga_r;
    assign falha             = falha_r;
    assign ocupado           = (estado_r != OCIOSO);
    assign contagem_municao  = contagem_r;
    assign torreta_carregada = (contagem_r != 4'd0);
    assign db_estado         = estado_r;

endmodule
